// File: rtl/flash_bridge_pkg.sv
// ---------------------------------------------------------------------------
// | Module : flash_bridge_pkg                                               |
// | Brief  : Shared types and constants for the 6809 flash bus bridge.      |
// | Rev    : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package flash_bridge_pkg;

    localparam int FLASH_ADDR_W = 12;
    localparam int DATA_W       = 8;
    localparam int TIMEOUT_W    = 10;

    // Byte handed back to the CPU when the flash controller never answers.
    localparam logic [DATA_W-1:0] READ_TIMEOUT_DATA = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_HOLD = 3'd3,
        ST_WR_CAP  = 3'd4,
        ST_WR_REQ  = 3'd5
    } state_t;

    // One posted write: flash byte address plus data.
    typedef struct packed {
        logic [FLASH_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]       data;
    } wr_entry_t;

endpackage

`default_nettype wire

// File: rtl/flash_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// | Module : flash_bus_bridge_if                                            |
// | Brief  : req/ack transaction channel between the bridge (master) and    |
// |          the SPI flash controller (slave). Names are bridge-relative.   |
// | Rev    : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

interface flash_bus_bridge_if import flash_bridge_pkg::*; ();

    logic                    o_req;
    logic                    o_req_rw;
    logic [FLASH_ADDR_W-1:0] o_req_addr;
    logic [DATA_W-1:0]       o_req_wdata;
    logic                    i_ack;
    logic [DATA_W-1:0]       i_rdata;

    modport master (
        output o_req, o_req_rw, o_req_addr, o_req_wdata,
        input  i_ack, i_rdata
    );

    modport slave (
        input  o_req, o_req_rw, o_req_addr, o_req_wdata,
        output i_ack, i_rdata
    );

endinterface

`default_nettype wire

// File: rtl/flash_bridge_wfifo.sv
// ---------------------------------------------------------------------------
// | Module : flash_bridge_wfifo                                             |
// | Brief  : 2-deep {addr,data} FIFO holding posted CPU writes. The head     |
// |          stays valid while its flash transaction is outstanding and is  |
// |          popped only when that transaction completes.                   |
// | Rev    : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module flash_bridge_wfifo import flash_bridge_pkg::*; (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      i_push,
    input  wire wr_entry_t i_push_data,
    input  wire logic      i_pop,
    output wr_entry_t      o_head,
    output logic           o_full,
    output logic           o_empty
);

    wr_entry_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       w_push;
    logic       w_pop;

    assign o_full  = (count_q == 2'd2);
    assign o_empty = (count_q == 2'd0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= i_push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) rd_ptr_q <= ~rd_ptr_q;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/flash_bus_bridge.sv
// ---------------------------------------------------------------------------
// | Module : flash_bus_bridge                                               |
// | Brief  : 6809-side front end for the SPI flash controller. Synchronises |
// |          E, decodes the flash window, issues one req/ack transaction    |
// |          per access and stretches the CPU through MRDY.                 |
// | Config : FLASH_BRIDGE_WRITE_POST_EN - post writes into a 2-entry FIFO.  |
// | Rev    : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module flash_bus_bridge import flash_bridge_pkg::*; #(
    parameter logic [15:0] BASE_ADDR      = 16'hE000,
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_E,
    input  wire logic [15:0]       i_ADDRESS_BUS,
    input  wire logic [DATA_W-1:0] i_DataBus,
    input  wire logic              i_RW,
    output logic [DATA_W-1:0]      o_DataBus,
    output logic                   o_data_oe,
    output logic                   o_MemoryReady,
    output logic                   o_timeout_err,
    flash_bus_bridge_if.master     fb
);

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    e_prev_q;
    logic                    w_e_s, w_e_rise, w_e_fall, w_hit;
    state_t                  state_q;
    logic [FLASH_ADDR_W-1:0] addr_q;
    logic                    req_q, req_rw_q;
    logic [FLASH_ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0]       req_wdata_q;
    logic [DATA_W-1:0]       data_q;
    logic                    oe_q, mrdy_q, err_q;
    logic [TIMEOUT_W-1:0]    cnt_q;
    logic                    w_ack, w_tmo, w_fifo_empty;

    assign w_e_s    = sync_q[SYNC_STAGES-1];
    assign w_e_rise = w_e_s && !e_prev_q;
    assign w_e_fall = !w_e_s && e_prev_q;
    assign w_hit    = (i_ADDRESS_BUS[15:12] == BASE_ADDR[15:12]);
    // An ack only counts while a request is actually outstanding.
    assign w_ack    = fb.i_ack && req_q;
    assign w_tmo    = req_q && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

`ifdef FLASH_BRIDGE_WRITE_POST_EN
    logic              cap_q;
    logic [DATA_W-1:0] cap_data_q;
    logic              w_push, w_pop, w_full;
    wr_entry_t         w_push_data, w_head;

    // Push at E fall, or later from the holding register if E fell while full.
    assign w_push      = (state_q == ST_WR_CAP) && (w_e_fall || cap_q) && !w_full;
    assign w_push_data = '{addr: addr_q, data: (cap_q ? cap_data_q : i_DataBus)};
    // The head leaves the FIFO when its transaction completes or is abandoned.
    assign w_pop       = req_q && (state_q != ST_RD_REQ) && (w_ack || w_tmo);

    flash_bridge_wfifo u_wfifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_fifo_empty)
    );
`else
    assign w_fifo_empty = 1'b1;
`endif

    // E synchroniser plus one extra flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            e_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], i_E};
            e_prev_q <= w_e_s;
        end
    end

    // Timeout counter runs only while a request is outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          cnt_q <= '0;
        else if (req_q && !w_ack && !w_tmo) cnt_q <= cnt_q + 1'b1;
        else                                cnt_q <= '0;
    end

    // Bus-cycle FSM with registered CPU and flash-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            req_q       <= 1'b0;
            req_rw_q    <= 1'b1;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            data_q      <= '0;
            oe_q        <= 1'b0;
            mrdy_q      <= 1'b1;
            err_q       <= 1'b0;
`ifdef FLASH_BRIDGE_WRITE_POST_EN
            cap_q       <= 1'b0;
            cap_data_q  <= '0;
`endif
        end else begin
`ifdef FLASH_BRIDGE_WRITE_POST_EN
            // Drain engine: never overlaps a read, which waits for an empty FIFO.
            if (state_q != ST_RD_REQ) begin
                if (req_q && (w_ack || w_tmo)) begin
                    req_q <= 1'b0;
                    if (!w_ack) err_q <= 1'b1;
                end else if (!req_q && !w_fifo_empty) begin
                    req_q       <= 1'b1;
                    req_rw_q    <= 1'b0;
                    req_addr_q  <= w_head.addr;
                    req_wdata_q <= w_head.data;
                end
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (w_e_rise && w_hit) begin
                        addr_q <= i_ADDRESS_BUS[FLASH_ADDR_W-1:0];
                        if (i_RW) begin
                            mrdy_q  <= 1'b0;
                            state_q <= ST_RD_WAIT;
                        end else begin
`ifdef FLASH_BRIDGE_WRITE_POST_EN
                            if (w_full) mrdy_q <= 1'b0;
`else
                            mrdy_q <= 1'b0;
`endif
                            state_q <= ST_WR_CAP;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (w_fifo_empty && !req_q) begin
                        req_q      <= 1'b1;
                        req_rw_q   <= 1'b1;
                        req_addr_q <= addr_q;
                        state_q    <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (w_ack || w_tmo) begin
                        req_q   <= 1'b0;
                        data_q  <= w_ack ? fb.i_rdata : READ_TIMEOUT_DATA;
                        oe_q    <= 1'b1;
                        mrdy_q  <= 1'b1;
                        if (!w_ack) err_q <= 1'b1;
                        state_q <= ST_RD_HOLD;
                    end
                end
                ST_RD_HOLD: begin
                    if (w_e_fall) begin
                        oe_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR_CAP: begin
`ifdef FLASH_BRIDGE_WRITE_POST_EN
                    if (w_push) begin
                        mrdy_q  <= 1'b1;
                        cap_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        if (!w_full) mrdy_q <= 1'b1;
                        if (w_e_fall) begin
                            cap_q      <= 1'b1;
                            cap_data_q <= i_DataBus;
                        end
                    end
`else
                    if (w_e_fall) begin
                        req_q       <= 1'b1;
                        req_rw_q    <= 1'b0;
                        req_addr_q  <= addr_q;
                        req_wdata_q <= i_DataBus;
                        state_q     <= ST_WR_REQ;
                    end
`endif
                end
                ST_WR_REQ: begin
                    if (w_ack || w_tmo) begin
                        req_q   <= 1'b0;
                        mrdy_q  <= 1'b1;
                        if (!w_ack) err_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_DataBus      = data_q;
    assign o_data_oe      = oe_q;
    assign o_MemoryReady  = mrdy_q;
    assign o_timeout_err  = err_q;
    assign fb.o_req       = req_q;
    assign fb.o_req_rw    = req_rw_q;
    assign fb.o_req_addr  = req_addr_q;
    assign fb.o_req_wdata = req_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_bus_bridge.sv
// ---------------------------------------------------------------------------
// | Module : tb_flash_bus_bridge                                            |
// | Brief  : Directed self-checking bench for flash_bus_bridge. Posted-     |
// |          write scenarios build when FLASH_BRIDGE_WRITE_POST_EN is set.  |
// | Rev    : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_flash_bus_bridge;

`ifdef FLASH_BRIDGE_WRITE_POST_EN
    localparam bit c_POSTED = 1'b1;
`else
    localparam bit c_POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        r_e;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_rw;
    logic [7:0]  w_dbus;
    logic        w_oe, w_mrdy, w_err;
    int          n_vec = 0;
    int          n_err = 0;
    bit          r_bad;
    bit          r_ok;
    int          r_len;

    flash_bus_bridge_if fb_if ();

    flash_bus_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .i_E           (r_e),
        .i_ADDRESS_BUS (r_addr),
        .i_DataBus     (r_wdata),
        .i_RW          (r_rw),
        .o_DataBus     (w_dbus),
        .o_data_oe     (w_oe),
        .o_MemoryReady (w_mrdy),
        .o_timeout_err (w_err),
        .fb            (fb_if)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for a request of the given direction.
    task automatic wait_req(input string tag, input logic rw, input int budget);
        r_ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fb_if.o_req && fb_if.o_req_rw == rw) begin
                r_ok = 1'b1;
                break;
            end
            tick(1);
        end
        check_vec(tag, 32'(r_ok), 32'd1);
    endtask

    task automatic pulse_ack(input logic [7:0] d);
        fb_if.i_ack   = 1'b1;
        fb_if.i_rdata = d;
        tick(1);
        fb_if.i_ack   = 1'b0;
        fb_if.i_rdata = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_dbus"},  32'(w_dbus),            32'h00);
        check_vec({tag, "_oe"},    32'(w_oe),              32'd0);
        check_vec({tag, "_mrdy"},  32'(w_mrdy),            32'd1);
        check_vec({tag, "_req"},   32'(fb_if.o_req),       32'd0);
        check_vec({tag, "_rw"},    32'(fb_if.o_req_rw),    32'd1);
        check_vec({tag, "_addr"},  32'(fb_if.o_req_addr),  32'h000);
        check_vec({tag, "_wdata"}, 32'(fb_if.o_req_wdata), 32'h00);
        check_vec({tag, "_err"},   32'(w_err),             32'd0);
    endtask

`ifdef FLASH_BRIDGE_WRITE_POST_EN
    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        r_addr  = a;
        r_rw    = 1'b0;
        r_wdata = d;
        r_e     = 1'b1;
        tick(6);
        r_e     = 1'b0;
        tick(6);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; r_e = 1'b0; r_addr = 16'h0000; r_wdata = 8'h00; r_rw = 1'b1;
        fb_if.i_ack = 1'b0; fb_if.i_rdata = 8'h00;
        tick(3);
        check_reset_vals("rst0");
        reset = 1'b0;
        tick(3);

        // 1: read hit E123, ack after 40 clocks with 5A
        r_addr = 16'hE123; r_rw = 1'b1; r_e = 1'b1;
        wait_req("t1_req_seen", 1'b1, 20);
        check_vec("t1_addr", 32'(fb_if.o_req_addr), 32'h123);
        check_vec("t1_mrdy_low", 32'(w_mrdy), 32'd0);
        r_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!fb_if.o_req || w_mrdy || w_oe) r_bad = 1'b1;
        end
        check_vec("t1_stretch", 32'(r_bad), 32'd0);
        pulse_ack(8'h5A);
        check_vec("t1_req_drop", 32'(fb_if.o_req), 32'd0);
        check_vec("t1_dbus", 32'(w_dbus), 32'h5A);
        check_vec("t1_oe", 32'(w_oe), 32'd1);
        check_vec("t1_mrdy_rel", 32'(w_mrdy), 32'd1);
        tick(1);
        r_e = 1'b0;
        tick(1);
        check_vec("t1_oe_hold", 32'(w_oe), 32'd1);
        tick(3);
        check_vec("t1_oe_off", 32'(w_oe), 32'd0);
        tick(2);

        // 2: write E010 <- C3, ack after 90 clocks
        r_addr = 16'hE010; r_rw = 1'b0; r_wdata = 8'hC3; r_e = 1'b1;
        tick(8);
        check_vec("t2_mrdy_cap", 32'(w_mrdy), c_POSTED ? 32'd1 : 32'd0);
        r_e = 1'b0;
        wait_req("t2_req_seen", 1'b0, 20);
        check_vec("t2_addr", 32'(fb_if.o_req_addr), 32'h010);
        check_vec("t2_wdata", 32'(fb_if.o_req_wdata), 32'hC3);
        r_bad = 1'b0;
        for (int i = 0; i < 90; i++) begin
            tick(1);
            if (!fb_if.o_req || w_mrdy != c_POSTED) r_bad = 1'b1;
        end
        check_vec("t2_hold", 32'(r_bad), 32'd0);
        pulse_ack(8'h00);
        check_vec("t2_req_drop", 32'(fb_if.o_req), 32'd0);
        check_vec("t2_mrdy_rel", 32'(w_mrdy), 32'd1);
        tick(3);

`ifdef FLASH_BRIDGE_WRITE_POST_EN
        // 3: three back-to-back posted writes, no ack yet
        do_write(16'hE100, 8'h11);
        check_vec("t3_head0_addr", 32'(fb_if.o_req_addr), 32'h100);
        do_write(16'hE101, 8'h22);
        r_addr = 16'hE102; r_rw = 1'b0; r_wdata = 8'h33; r_e = 1'b1;
        tick(6);
        check_vec("t3_full_stall", 32'(w_mrdy), 32'd0);
        r_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (w_mrdy) r_bad = 1'b1;
        end
        check_vec("t3_stall_hold", 32'(r_bad), 32'd0);
        check_vec("t3_head0_data", 32'(fb_if.o_req_wdata), 32'h11);
        pulse_ack(8'h00);
        tick(3);
        check_vec("t3_release", 32'(w_mrdy), 32'd1);
        check_vec("t3_head1_req", 32'(fb_if.o_req), 32'd1);
        check_vec("t3_head1_addr", 32'(fb_if.o_req_addr), 32'h101);
        check_vec("t3_head1_data", 32'(fb_if.o_req_wdata), 32'h22);
        r_e = 1'b0;
        tick(6);
        pulse_ack(8'h00);
        tick(2);
        check_vec("t3_head2_addr", 32'(fb_if.o_req_addr), 32'h102);
        check_vec("t3_head2_data", 32'(fb_if.o_req_wdata), 32'h33);
        pulse_ack(8'h00);
        tick(2);
        check_vec("t3_drained", 32'(fb_if.o_req), 32'd0);

        // 4: write E001 then read E001; the read must wait for the write ack
        do_write(16'hE001, 8'h77);
        check_vec("t4_wr_rw", 32'(fb_if.o_req_rw), 32'd0);
        r_addr = 16'hE001; r_rw = 1'b1; r_e = 1'b1;
        r_bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (fb_if.o_req && fb_if.o_req_rw) r_bad = 1'b1;
        end
        check_vec("t4_no_early_read", 32'(r_bad), 32'd0);
        check_vec("t4_mrdy_wait", 32'(w_mrdy), 32'd0);
        pulse_ack(8'h00);
        wait_req("t4_rd_req_seen", 1'b1, 20);
        check_vec("t4_rd_addr", 32'(fb_if.o_req_addr), 32'h001);
        pulse_ack(8'h9C);
        check_vec("t4_dbus", 32'(w_dbus), 32'h9C);
        r_e = 1'b0;
        tick(6);
`endif

        // 5: read with no ack -> timeout after 1024 clocks
        r_addr = 16'hE0FF; r_rw = 1'b1; r_e = 1'b1;
        wait_req("t5_req_seen", 1'b1, 20);
        r_len = 0;
        while (fb_if.o_req && r_len < 1100) begin
            r_len++;
            tick(1);
        end
        check_vec("t5_req_len", 32'(r_len), 32'd1024);
        check_vec("t5_req_drop", 32'(fb_if.o_req), 32'd0);
        check_vec("t5_err", 32'(w_err), 32'd1);
        check_vec("t5_dbus", 32'(w_dbus), 32'hFF);
        check_vec("t5_mrdy", 32'(w_mrdy), 32'd1);
        r_e = 1'b0;
        tick(5);
        check_vec("t5_oe_off", 32'(w_oe), 32'd0);

        // 6: reset during a read request, then a window miss
        r_addr = 16'hE200; r_rw = 1'b1; r_e = 1'b1;
        wait_req("t6_req_seen", 1'b1, 20);
        reset = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        r_e = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(3);
        r_addr = 16'h8000; r_rw = 1'b1; r_e = 1'b1;
        r_bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (fb_if.o_req || !w_mrdy) r_bad = 1'b1;
        end
        check_vec("t6_miss_quiet", 32'(r_bad), 32'd0);
        r_e = 1'b0;
        tick(5);
        check_vec("t6_miss_oe", 32'(w_oe), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
